nn_test_sequencer: RTL and testbench
====================================

NN_TEST_SEQUENCER -- requirements
Module: nn_test_sequencer

Interface
REQ-001 Parameter ADDR_W, default MM_DEPTH, memory-map address width.
REQ-002 Parameter DATA_W, default MM_WIDTH, write-data width.
REQ-003 Parameter Q_W, default Q_DEPTH, read-data width; read data is signed fixed-point.
REQ-004 Parameter ACC_W, default 40, squared-error accumulator width.
REQ-005 Parameter CTRL_ADDR, default 16'hC000, accelerator start-register address.
REQ-006 Parameter READ_LAT, default 1, cycles from read_enable to valid read_data (range 1..4).
REQ-007 Parameter GUARD, default 4, idle cycles after start before polling available.
REQ-008 Parameter TIMEOUT, default 65535, maximum cycles spent polling available.
REQ-009 clk  in  1  single clock; all logic samples on its rising edge.
REQ-010 reset  in  1  asynchronous, active-low reset.
REQ-011 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; a command transfers when both are high on a rising edge.
REQ-012 cmd_op  in  2  command opcode: 0 WRITE, 1 START, 2 CHECK, 3 END.
REQ-013 cmd_addr / cmd_data  in  ADDR_W / DATA_W  target address; write data, or expected value for CHECK (low Q_W bits).
REQ-014 write_enable, write_addr, write_data  out  1, ADDR_W, DATA_W  accelerator write port.
REQ-015 read_enable, read_addr  out  1, ADDR_W  accelerator read port.
REQ-016 read_data / available  in  Q_W / 1  accelerator read data; accelerator-done status.
REQ-017 res_valid  out  1  one-cycle result strobe.
REQ-018 res_sq_err / res_checks / res_timeout  out  ACC_W / 16 / 1  summed squared error; CHECK count; timeout flag.
REQ-019 busy  out  1  high in every state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, WRITE, START, GUARD, POLL, READ, CAPTURE, REPORT.
REQ-021 cmd_ready SHALL be high only in IDLE; each accepted command leaves IDLE on the following cycle.
REQ-022 WRITE SHALL drive write_enable high for exactly one cycle with the registered address and data, then return to IDLE.
REQ-023 START SHALL drive one write cycle with address CTRL_ADDR and data 1, then enter GUARD.
REQ-024 GUARD SHALL last exactly GUARD cycles, then enter POLL.
REQ-025 POLL SHALL return to IDLE on the first cycle available is high.
REQ-026 If available stays low for TIMEOUT cycles, POLL SHALL set sticky res_timeout and return to IDLE.
REQ-027 CHECK SHALL drive read_enable high for one cycle (READ), then wait READ_LAT cycles before sampling read_data (CAPTURE).
REQ-028 diff SHALL be computed on Q_W+1 bits as signed(read_data) - signed(expected).
REQ-029 diff*diff SHALL be added into the accumulator, saturating at 2^ACC_W-1.
REQ-030 Each CHECK SHALL increment the check counter, saturating at 16'hFFFF.
REQ-031 CHECK with read_data containing X/Z SHALL behave as an ordinary check (no special handling in RTL).
REQ-032 END SHALL enter REPORT.
REQ-033 REPORT SHALL assert res_valid for one cycle and present the accumulator, counter and timeout flag.
REQ-034 The accumulator, counter and timeout flag SHALL clear on the cycle after REPORT.
REQ-035 res_sq_err, res_checks and res_timeout SHALL hold their last reported values until the next REPORT.
REQ-036 write_addr, write_data and read_addr SHALL hold their last values when their enable is low.
REQ-037 END with zero preceding CHECKs SHALL report res_sq_err = 0 and res_checks = 0.

Reset
REQ-038 Asserting reset SHALL immediately force the IDLE state, clear all counters, accumulator and flags, and drive every output to 0, including mid-transaction.
REQ-039 After deassertion, cmd_ready SHALL be high on the first rising edge.

Structure
REQ-040 The op-code enum, FSM state typedef and CTRL_ADDR default SHALL be defined in the shared definitions package, alongside MM_DEPTH, MM_WIDTH and Q_DEPTH.
REQ-041 The squared-error datapath (diff, square, saturating add) SHALL be one sub-module, sq_err_accumulator.

Verification
REQ-042 WRITE addr 0x0010 data 0x1234 -> exactly one write_enable cycle with 0x0010 / 0x1234; cmd_ready low for one cycle.
REQ-043 START, available rising 10 cycles after GUARD ends -> one write of 0xC000 / 1, busy for 1+GUARD+10 cycles, res_timeout 0.
REQ-044 CHECK with read_data 0x1000 and expected 0x0F00, then END -> res_sq_err 0x10000, res_checks 1, res_valid for one cycle.
REQ-045 Two CHECKs with read_data 0x7FFF / expected 0x8000 and ACC_W = 32 -> accumulator saturates at 0xFFFFFFFF.
REQ-046 START with available held low, TIMEOUT = 20 -> return to IDLE after GUARD+20 cycles, END reports res_timeout 1.
REQ-047 Reset asserted during POLL and during CAPTURE -> all outputs 0 immediately; cmd_ready high one edge after release; the next END reports zeros.

Source files
------------

// File: rtl/nn_test_sequencer_pkg.sv
// Shared definitions for the accelerator test sequencer: memory-map widths,
// command opcodes and FSM state encoding.
package nn_test_sequencer_pkg;

  localparam int MM_DEPTH = 16;
  localparam int MM_WIDTH = 16;
  localparam int Q_DEPTH  = 16;

  localparam logic [15:0] CTRL_ADDR_DEFAULT = 16'hC000;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_START = 2'd1,
    OP_CHECK = 2'd2,
    OP_END   = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_START,
    S_GUARD,
    S_POLL,
    S_READ,
    S_CAPTURE,
    S_REPORT
  } state_t;

endpackage

// File: rtl/nn_test_sequencer_if.sv
// Command, accelerator memory-port and result signals of the test sequencer.
interface nn_test_sequencer_if
  import nn_test_sequencer_pkg::*;
#(
  parameter int ADDR_W = MM_DEPTH,
  parameter int DATA_W = MM_WIDTH,
  parameter int Q_W    = Q_DEPTH,
  parameter int ACC_W  = 40
);
  logic              cmd_valid;
  logic              cmd_ready;
  op_t               cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              read_enable;
  logic [ADDR_W-1:0] read_addr;
  logic [Q_W-1:0]    read_data;
  logic              available;

  logic              res_valid;
  logic [ACC_W-1:0]  res_sq_err;
  logic [15:0]       res_checks;
  logic              res_timeout;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, read_data, available,
    output cmd_ready, write_enable, write_addr, write_data, read_enable, read_addr,
           res_valid, res_sq_err, res_checks, res_timeout, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, read_data, available,
    input  cmd_ready, write_enable, write_addr, write_data, read_enable, read_addr,
           res_valid, res_sq_err, res_checks, res_timeout, busy
  );

endinterface

// File: rtl/nn_test_sequencer_sq_err_accumulator.sv
// Squared-error datapath: signed difference, square, and saturating
// accumulation into an ACC_W-bit register.
module sq_err_accumulator #(
  parameter int Q_W   = 16,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [Q_W-1:0]   i_read_data,
  input  logic [Q_W-1:0]   i_expected,
  output logic [ACC_W-1:0] o_acc
);
  localparam int SQ_W  = 2 * (Q_W + 1);
  localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  logic signed [Q_W:0]    w_diff;
  logic signed [SQ_W-1:0] w_sq;
  logic [SUM_W-1:0]       w_sum;
  logic [ACC_W-1:0]       r_acc;

  // One extra bit keeps full-scale differences (e.g. 0x7FFF - 0x8000) exact.
  assign w_diff = $signed({i_read_data[Q_W-1], i_read_data})
                - $signed({i_expected[Q_W-1], i_expected});
  assign w_sq   = SQ_W'(w_diff) * SQ_W'(w_diff);
  assign w_sum  = SUM_W'(r_acc) + SUM_W'(unsigned'(w_sq));
  assign o_acc  = r_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= (w_sum > ACC_MAX) ? '1 : w_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/nn_test_sequencer.sv
// Command-driven test sequencer: writes accelerator memory, starts and polls
// the accelerator, and accumulates squared error of read-back checks.
module nn_test_sequencer
  import nn_test_sequencer_pkg::*;
#(
  parameter int ADDR_W   = MM_DEPTH,
  parameter int DATA_W   = MM_WIDTH,
  parameter int Q_W      = Q_DEPTH,
  parameter int ACC_W    = 40,
  parameter logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(CTRL_ADDR_DEFAULT),
  parameter int READ_LAT = 1,
  parameter int GUARD    = 4,
  parameter int TIMEOUT  = 65535
) (
  input logic              clk,
  input logic              reset,
  nn_test_sequencer_if.master bus
);
  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_cnt;
  logic              w_cmd_ready;
  logic              w_accept;
  logic              w_capture;
  logic              w_timeout_hit;
  logic [ADDR_W-1:0] r_write_addr;
  logic [DATA_W-1:0] r_write_data;
  logic [ADDR_W-1:0] r_read_addr;
  logic [Q_W-1:0]    r_expected;
  logic [15:0]       r_checks;
  logic              r_timeout;
  logic [ACC_W-1:0]  w_acc;
  logic [ACC_W-1:0]  r_res_sq_err;
  logic [15:0]       r_res_checks;
  logic              r_res_timeout;

  // Gating with reset keeps every output low while reset is held.
  assign w_cmd_ready = reset && (r_state == S_IDLE);
  assign w_accept    = bus.cmd_valid && w_cmd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_capture     = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.cmd_op)
            OP_WRITE: w_next = S_WRITE;
            OP_START: w_next = S_START;
            OP_CHECK: w_next = S_READ;
            default:  w_next = S_REPORT;
          endcase
        end
      end
      S_WRITE:  w_next = S_IDLE;
      S_START:  w_next = (GUARD == 0) ? S_POLL : S_GUARD;
      S_GUARD:  if (r_cnt == 16'(GUARD - 1)) w_next = S_POLL;
      S_POLL: begin
        if (bus.available) begin
          w_next = S_IDLE;
        end else if (r_cnt == 16'(TIMEOUT - 1)) begin
          w_next        = S_IDLE;
          w_timeout_hit = 1'b1;
        end
      end
      S_READ:   w_next = S_CAPTURE;
      S_CAPTURE: begin
        if (r_cnt == 16'(READ_LAT - 1)) begin
          w_next    = S_IDLE;
          w_capture = 1'b1;
        end
      end
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt         <= '0;
      r_write_addr  <= '0;
      r_write_data  <= '0;
      r_read_addr   <= '0;
      r_expected    <= '0;
      r_checks      <= '0;
      r_timeout     <= 1'b0;
      r_res_sq_err  <= '0;
      r_res_checks  <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + 16'd1;
      if (w_accept) begin
        case (bus.cmd_op)
          OP_WRITE: begin
            r_write_addr <= bus.cmd_addr;
            r_write_data <= bus.cmd_data;
          end
          OP_START: begin
            r_write_addr <= CTRL_ADDR;
            r_write_data <= DATA_W'(1);
          end
          OP_CHECK: begin
            r_read_addr <= bus.cmd_addr;
            r_expected  <= bus.cmd_data[Q_W-1:0];
          end
          default: begin
            r_res_sq_err  <= w_acc;
            r_res_checks  <= r_checks;
            r_res_timeout <= r_timeout;
          end
        endcase
      end
      if (r_state == S_REPORT) begin
        r_checks  <= '0;
        r_timeout <= 1'b0;
      end else begin
        if (w_capture && (r_checks != 16'hFFFF)) r_checks <= r_checks + 16'd1;
        if (w_timeout_hit) r_timeout <= 1'b1;
      end
    end
  end

  sq_err_accumulator #(
    .Q_W   (Q_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk         (clk),
    .reset       (reset),
    .i_en        (w_capture),
    .i_clr       (r_state == S_REPORT),
    .i_read_data (bus.read_data),
    .i_expected  (r_expected),
    .o_acc       (w_acc)
  );

  assign bus.cmd_ready    = w_cmd_ready;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.write_enable = (r_state == S_WRITE) || (r_state == S_START);
  assign bus.write_addr   = r_write_addr;
  assign bus.write_data   = r_write_data;
  assign bus.read_enable  = (r_state == S_READ);
  assign bus.read_addr    = r_read_addr;
  assign bus.res_valid    = (r_state == S_REPORT);
  assign bus.res_sq_err   = r_res_sq_err;
  assign bus.res_checks   = r_res_checks;
  assign bus.res_timeout  = r_res_timeout;

endmodule

// File: tb/tb_nn_test_sequencer.sv
// Directed bench for nn_test_sequencer with a READ_LAT-cycle memory model.
module tb_nn_test_sequencer;
  import nn_test_sequencer_pkg::*;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int QW   = 16;
  localparam int ACCW = 32;
  localparam int GRD  = 4;
  localparam int TMO  = 20;
  localparam int RL   = 2;
  localparam logic [QW-1:0] JUNK = 16'h0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   we_cnt  = 0;
  logic [QW-1:0] rd_val  = '0;
  logic [RL-1:0] rd_pipe = '0;

  nn_test_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .Q_W(QW), .ACC_W(ACCW)) bus ();

  nn_test_sequencer #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .Q_W      (QW),
    .ACC_W    (ACCW),
    .READ_LAT (RL),
    .GUARD    (GRD),
    .TIMEOUT  (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Read data is only valid exactly RL cycles after the read strobe.
  always @(posedge clk) rd_pipe <= {rd_pipe[RL-2:0], bus.read_enable};
  assign bus.read_data = rd_pipe[RL-1] ? rd_val : JUNK;

  always @(negedge clk) if (bus.write_enable) we_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input op_t op, input logic [15:0] addr, input logic [15:0] data);
    int n = 0;
    @(negedge clk);
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle", bus.busy, 0);
  endtask

  task automatic count_busy(input int avail_at, output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 500) begin
      cycles++;
      if (cycles == avail_at) bus.available = 1'b1;
      @(negedge clk);
    end
    bus.available = 1'b0;
  endtask

  task automatic do_check(input logic [15:0] rd, input logic [15:0] exp, input logic [15:0] addr);
    rd_val = rd;
    send_cmd(OP_CHECK, addr, exp);
    chk("rd_en", bus.read_enable, 1);
    chk("rd_addr", bus.read_addr, addr);
    wait_idle();
  endtask

  task automatic do_end(input logic [31:0] sq, input logic [15:0] nchk, input logic to);
    send_cmd(OP_END, 16'h0000, 16'h0000);
    chk("res_valid", bus.res_valid, 1);
    chk("res_sq_err", bus.res_sq_err, sq);
    chk("res_checks", bus.res_checks, nchk);
    chk("res_timeout", bus.res_timeout, to);
    @(negedge clk);
    chk("res_valid_low", bus.res_valid, 0);
    chk("res_sq_hold", bus.res_sq_err, sq);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int base;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.available = 1'b0;

    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_we", bus.write_enable, 0);
    chk("rst_sq", bus.res_sq_err, 0);
    chk("rst_checks", bus.res_checks, 0);
    reset = 1'b1;
    #1 chk("rel_ready", bus.cmd_ready, 1);

    send_cmd(OP_WRITE, 16'h0010, 16'h1234);
    chk("wr_we", bus.write_enable, 1);
    chk("wr_addr", bus.write_addr, 16'h0010);
    chk("wr_data", bus.write_data, 16'h1234);
    chk("wr_ready_low", bus.cmd_ready, 0);
    @(negedge clk);
    chk("wr_we_low", bus.write_enable, 0);
    chk("wr_ready_back", bus.cmd_ready, 1);
    chk("wr_addr_hold", bus.write_addr, 16'h0010);

    base = we_cnt;
    send_cmd(OP_START, 16'h0000, 16'h0000);
    chk("st_we", bus.write_enable, 1);
    chk("st_addr", bus.write_addr, 16'hC000);
    chk("st_data", bus.write_data, 16'h0001);
    count_busy(1 + GRD + 10, cyc);
    chk("st_busy_cycles", cyc, 1 + GRD + 10);
    chk("st_one_write", we_cnt - base, 1);

    do_end(32'h0, 16'd0, 1'b0);

    do_check(16'h1000, 16'h0F00, 16'h0020);
    do_end(32'h0001_0000, 16'd1, 1'b0);

    do_check(16'h7FFF, 16'h8000, 16'h0021);
    do_end(32'hFFFE_0001, 16'd1, 1'b0);

    do_check(16'h7FFF, 16'h8000, 16'h0022);
    do_check(16'h7FFF, 16'h8000, 16'h0023);
    do_end(32'hFFFF_FFFF, 16'd2, 1'b0);

    send_cmd(OP_START, 16'h0000, 16'h0000);
    repeat (GRD + 3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rp_busy", bus.busy, 0);
    chk("rp_ready", bus.cmd_ready, 0);
    chk("rp_we", bus.write_enable, 0);
    chk("rp_waddr", bus.write_addr, 0);
    chk("rp_sq", bus.res_sq_err, 0);
    chk("rp_checks", bus.res_checks, 0);
    chk("rp_valid", bus.res_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rp_rel_ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1 chk("rp_edge_ready", bus.cmd_ready, 1);

    do_check(16'h1000, 16'h0F00, 16'h0030);
    send_cmd(OP_CHECK, 16'h0031, 16'h0F00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rc_re", bus.read_enable, 0);
    chk("rc_raddr", bus.read_addr, 0);
    chk("rc_busy", bus.busy, 0);
    #3 reset = 1'b1;
    do_end(32'h0, 16'd0, 1'b0);

    send_cmd(OP_START, 16'h0000, 16'h0000);
    count_busy(0, cyc);
    chk("to_busy_cycles", cyc, 1 + GRD + TMO);
    do_end(32'h0, 16'd0, 1'b1);
    do_end(32'h0, 16'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
